mp_add_seq: RTL and testbench

//  Multi-precision add sequencer. Accepts WORDS*32-bit operands with a start/busy/done handshake.

---
 rtl/mp_add_pkg.sv | 22 ++
 rtl/mp_add_seq_if.sv | 41 ++++
 rtl/mp_add_seq.sv | 145 ++++++++++++++
 tb/tb_mp_add_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add sequencer: slice width,
// default sizing, FSM state encoding and a counter-width helper.
package mp_add_pkg;

    localparam int SLICE_W     = 32;
    localparam int DEF_WORDS   = 4;
    localparam int DEF_ADD_LAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Width of a counter that must hold values 0..n-1. The result is never
    // below 1, so a single-slice or single-cycle build still gets a legal vector.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Interfaces for the add sequencer: the requester handshake (start/busy/done
// plus operands and result) and the 32-bit bus to the registered adder stage.
// The ovf signal exists only when SIGNED_OVF_EN is defined.
interface mp_add_seq_if
    import mp_add_pkg::*;
#(
    parameter int WORDS = DEF_WORDS
) ();
    localparam int W = SLICE_W * WORDS;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         co;
`ifdef SIGNED_OVF_EN
    logic         ovf;

    modport master (output start, a, b, ci, input busy, done, sum, co, ovf);
    modport slave  (input start, a, b, ci, output busy, done, sum, co, ovf);
`else
    modport master (output start, a, b, ci, input busy, done, sum, co);
    modport slave  (input start, a, b, ci, output busy, done, sum, co);
`endif
endinterface

interface mp_add_bus_if
    import mp_add_pkg::*;
();
    logic [SLICE_W-1:0] add_a;
    logic [SLICE_W-1:0] add_b;
    logic               add_ci;
    logic [SLICE_W-1:0] add_s;
    logic               add_co;

    modport master (output add_a, add_b, add_ci, input add_s, add_co);
    modport slave  (input add_a, add_b, add_ci, output add_s, add_co);
endinterface

// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: feeds a registered 32-bit adder one slice at a
// time (LSW first), chains the carry and assembles the WORDS*32-bit sum.
// Optional signed overflow flag is built when SIGNED_OVF_EN is defined.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int WORDS   = DEF_WORDS,
    parameter int ADD_LAT = DEF_ADD_LAT
) (
    input  logic          clk,
    input  logic          reset_n,
    mp_add_seq_if.slave   req,
    mp_add_bus_if.master  bus
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = cnt_w(WORDS);
    localparam int CNT_W = cnt_w(ADD_LAT);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(ADD_LAT - 1);

    state_e             state_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [CNT_W-1:0]   wcnt_q;
    logic [W-1:0]       sum_q;
    logic               co_q;
    logic               busy_q;
    logic               done_q;
    logic [SLICE_W-1:0] add_a_q;
    logic [SLICE_W-1:0] add_b_q;
    logic               add_ci_q;
    logic               last_slice;
`ifdef SIGNED_OVF_EN
    logic               ovf_q;
`endif

    always_comb begin
        idx_d      = idx_q + 1'b1;
        last_slice = (idx_q == LAST_IDX);
    end

    // The adder bus is loaded on the edge that enters ISSUE, so the slice is
    // already on add_a/add_b/add_ci during the ISSUE cycle and stays there
    // through the whole WAIT window.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: the operand and result registers are reset too; nothing
            // here is a RAM, and a known-zero sum/bus after reset is visible.
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            wcnt_q   <= '0;
            sum_q    <= '0;
            co_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            add_a_q  <= '0;
            add_b_q  <= '0;
            add_ci_q <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            // NOTE: every register here uses <=, so all right-hand sides read
            // the pre-edge values regardless of statement order.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req.start) begin
                        a_q      <= req.a;
                        b_q      <= req.b;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        add_a_q  <= req.a[SLICE_W-1:0];
                        add_b_q  <= req.b[SLICE_W-1:0];
                        add_ci_q <= req.ci;
`ifdef SIGNED_OVF_EN
                        ovf_q    <= 1'b0;
`endif
                        state_q  <= ISSUE;
                    end
                end

                ISSUE: begin
                    wcnt_q  <= WAIT_LOAD;
                    state_q <= WAIT;
                end

                WAIT: begin
                    if (wcnt_q != '0) begin
                        wcnt_q <= wcnt_q - 1'b1;
                    end else begin
                        sum_q[SLICE_W*idx_q +: SLICE_W] <= bus.add_s;
                        if (last_slice) begin
                            co_q     <= bus.add_co;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            add_a_q  <= '0;
                            add_b_q  <= '0;
                            add_ci_q <= 1'b0;
`ifdef SIGNED_OVF_EN
                            // MSW of the sum lands on this same edge, so take
                            // its sign straight from the adder output.
                            ovf_q    <= (a_q[W-1] == b_q[W-1]) &&
                                        (bus.add_s[SLICE_W-1] != a_q[W-1]);
`endif
                            state_q  <= DONE;
                        end else begin
                            idx_q    <= idx_d;
                            add_a_q  <= a_q[SLICE_W*idx_d +: SLICE_W];
                            add_b_q  <= b_q[SLICE_W*idx_d +: SLICE_W];
                            add_ci_q <= bus.add_co;
                            state_q  <= ISSUE;
                        end
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req.busy   = busy_q;
    assign req.done   = done_q;
    assign req.sum    = sum_q;
    assign req.co     = co_q;
`ifdef SIGNED_OVF_EN
    assign req.ovf    = ovf_q;
`endif
    assign bus.add_a  = add_a_q;
    assign bus.add_b  = add_b_q;
    assign bus.add_ci = add_ci_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq (WORDS=4, ADD_LAT=2) with a two-stage
// registered 32-bit adder attached; SIGNED_OVF_EN adds the overflow vectors.
module tb_mp_add_seq;
    import mp_add_pkg::*;

    localparam int WORDS   = 4;
    localparam int ADD_LAT = 2;
    localparam int W       = SLICE_W * WORDS;
    localparam int LAT     = WORDS * (ADD_LAT + 1);   // edges from accept to done

    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mp_add_seq_if #(.WORDS(WORDS)) req ();
    mp_add_bus_if                  bus ();

    mp_add_seq #(.WORDS(WORDS), .ADD_LAT(ADD_LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .bus     (bus)
    );

    // Registered adder: result valid ADD_LAT=2 cycles after operands are driven.
    logic [31:0] s1 = '0, s2 = '0;
    logic        c1 = 1'b0, c2 = 1'b0;
    always @(posedge clk) begin
        {c1, s1} <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_ci};
        {c2, s2} <= {c1, s1};
    end
    assign bus.add_s  = s2;
    assign bus.add_co = c2;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int exp_edges);
        int n;
        bit gap;
        n   = 0;
        gap = 1'b0;
        while (n < 64) begin
            tick();
            n++;
            if (req.done === 1'b1) break;
            if (req.busy !== 1'b1) gap = 1'b1;
        end
        check({tag, " latency"}, W'(n), W'(exp_edges));
        check({tag, " busy continuous"}, W'(gap), W'(0));
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        req.a     = a;
        req.b     = b;
        req.ci    = ci;
        req.start = 1'b1;
        tick();
        req.start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic [W-1:0] exp_sum, input logic exp_co);
        accept(a, b, ci);
        check({tag, " busy after accept"}, W'(req.busy), W'(1));
        wait_done(tag, LAT);
        check({tag, " sum"}, req.sum, exp_sum);
        check({tag, " co"}, W'(req.co), W'(exp_co));
        check({tag, " busy at done"}, W'(req.busy), W'(0));
        tick();
        check({tag, " single done pulse"}, W'(req.done), W'(0));
        check({tag, " sum held"}, req.sum, exp_sum);
    endtask

    initial begin
        req.start = 1'b0;
        req.a     = '0;
        req.b     = '0;
        req.ci    = 1'b0;
        tick();
        tick();
        check("reset busy", W'(req.busy), W'(0));
        check("reset done", W'(req.done), W'(0));
        check("reset sum", req.sum, '0);
        check("reset co", W'(req.co), W'(0));
        check("reset add_a", W'(bus.add_a), W'(0));
        check("reset add_ci", W'(bus.add_ci), W'(0));
        reset_n = 1'b1;
        tick();

        // 1: all ones + 1 ripples a carry through every slice
        run_op("t1", ONES, W'(1), 1'b0, '0, 1'b1);
        check("t1 idle add_a zero", W'(bus.add_a), W'(0));

        // 2: carry from slice 0 into slice 1, bus contents per slice
        accept(W'(32'hFFFF_FFFF), W'(1), 1'b0);
        check("t2 slice0 add_a", W'(bus.add_a), W'(32'hFFFF_FFFF));
        check("t2 slice0 add_b", W'(bus.add_b), W'(1));
        check("t2 slice0 add_ci", W'(bus.add_ci), W'(0));
        repeat (3) tick();
        check("t2 slice1 add_a", W'(bus.add_a), W'(0));
        check("t2 slice1 add_ci", W'(bus.add_ci), W'(1));
        wait_done("t2", LAT - 3);
        check("t2 sum", req.sum, {64'd0, 32'd1, 32'd0});
        check("t2 co", W'(req.co), W'(0));
        tick();

        // 3: carry-in only, then MSB+MSB overflows out of bit W
        run_op("t3a", '0, '0, 1'b1, W'(1), 1'b0);
        run_op("t3b", MSB, MSB, 1'b0, '0, 1'b1);

        // start held through the done cycle: ignored there, accepted one later
        accept(W'(5), W'(6), 1'b0);
        wait_done("tdone", LAT);
        req.a     = W'(1);
        req.b     = W'(2);
        req.ci    = 1'b0;
        req.start = 1'b1;
        tick();
        check("tdone start ignored in DONE", W'(req.busy), W'(0));
        check("tdone sum held", req.sum, W'(11));
        tick();
        req.start = 1'b0;
        check("tdone accepted next cycle", W'(req.busy), W'(1));
        wait_done("tdone2", LAT);
        check("tdone2 sum", req.sum, W'(3));
        tick();

        // 4: second start mid-operation is dropped without touching operands
        accept(ONES, W'(1), 1'b0);
        repeat (4) tick();
        req.a     = ONES;
        req.b     = ONES;
        req.start = 1'b1;
        tick();
        req.start = 1'b0;
        wait_done("t4", LAT - 5);
        check("t4 sum", req.sum, '0);
        check("t4 co", W'(req.co), W'(1));
        tick();
        check("t4 single done", W'(req.done), W'(0));
        repeat (3) tick();
        check("t4 no queued op", W'(req.busy), W'(0));

        // 5: reset mid-operation aborts with no done
        accept(W'(5), W'(7), 1'b0);
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        check("t5 busy after reset", W'(req.busy), W'(0));
        check("t5 done after reset", W'(req.done), W'(0));
        check("t5 add_a after reset", W'(bus.add_a), W'(0));
        check("t5 add_b after reset", W'(bus.add_b), W'(0));
        check("t5 add_ci after reset", W'(bus.add_ci), W'(0));
        reset_n = 1'b1;
        begin
            bit saw_done;
            saw_done = 1'b0;
            repeat (15) begin
                tick();
                if (req.done === 1'b1) saw_done = 1'b1;
            end
            check("t5 no done after abort", W'(saw_done), W'(0));
        end
        run_op("t5 restart",
               {32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002},
               {32'h0000_0002, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
               1'b1,
               {32'h0000_0004, 32'h0000_0000, 32'h0000_0001, 32'h0000_0002},
               1'b0);

`ifdef SIGNED_OVF_EN
        // 6: signed overflow flag
        run_op("t6a", {1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, MSB, 1'b0);
        check("t6a ovf", W'(req.ovf), W'(1));
        accept(ONES, W'(1), 1'b0);
        check("t6 ovf cleared on accept", W'(req.ovf), W'(0));
        wait_done("t6b", LAT);
        check("t6b sum", req.sum, '0);
        check("t6b ovf", W'(req.ovf), W'(0));
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
